// File: rtl/operand_forward_unit_pkg.sv
// Shared constants and helpers for the operand forwarding network.
package operand_forward_unit_pkg;

    // Select code meaning "take the register-file value".
    localparam int FWD_SEL_RF = 0;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/operand_forward_unit_if.sv
// EX/ID operand bus between the pipeline and the forwarding network.
interface operand_forward_unit_if
    import operand_forward_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int CNT_W     = 16
);
    localparam int SEL_W = sel_width(FWD_DEPTH);

    logic                                  stall_i;
    logic                                  flush_i;
    logic                                  ex_valid_i;
    logic [REG_AW-1:0]                     ex_rd_i;
    logic                                  ex_regwrite_i;
    logic                                  ex_memread_i;
    logic [NUM_SRC-1:0][REG_AW-1:0]        ex_rs_i;
    logic [NUM_SRC-1:0][DATA_W-1:0]        ex_rf_data_i;
    logic [NUM_SRC-1:0][REG_AW-1:0]        id_rs_i;
    logic [NUM_SRC-1:0]                    id_rs_used_i;
    logic [FWD_DEPTH-1:0][DATA_W-1:0]      stage_data_i;
    logic [NUM_SRC-1:0][DATA_W-1:0]        ex_opnd_o;
    logic [NUM_SRC-1:0][SEL_W-1:0]         fwd_sel_o;
    logic                                  load_use_stall_o;
    logic [CNT_W-1:0]                      fwd_hits_o;

    modport master (
        output stall_i, flush_i, ex_valid_i, ex_rd_i, ex_regwrite_i, ex_memread_i,
               ex_rs_i, ex_rf_data_i, id_rs_i, id_rs_used_i, stage_data_i,
        input  ex_opnd_o, fwd_sel_o, load_use_stall_o, fwd_hits_o
    );

    modport slave (
        input  stall_i, flush_i, ex_valid_i, ex_rd_i, ex_regwrite_i, ex_memread_i,
               ex_rs_i, ex_rf_data_i, id_rs_i, id_rs_used_i, stage_data_i,
        output ex_opnd_o, fwd_sel_o, load_use_stall_o, fwd_hits_o
    );

endinterface

// File: rtl/operand_forward_unit_sel.sv
// One source channel: priority compare of rs against all producer tags plus data mux.
module fwd_operand_select #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = 2
) (
    input  logic [REG_AW-1:0]                rs_i,
    input  logic [DATA_W-1:0]                rf_data_i,
    input  logic [FWD_DEPTH-1:0]             fwd_en_i,
    input  logic [FWD_DEPTH-1:0][REG_AW-1:0] tag_rd_i,
    input  logic [FWD_DEPTH-1:0][DATA_W-1:0] stage_data_i,
    output logic [SEL_W-1:0]                 sel_o,
    output logic [DATA_W-1:0]                opnd_o
);

    // Scan oldest to youngest so the youngest match is the last write.
    always_comb begin
        sel_o  = '0;
        opnd_o = rf_data_i;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (fwd_en_i[k] && (tag_rd_i[k] == rs_i)) begin
                sel_o  = SEL_W'(k + 1);
                opnd_o = stage_data_i[k];
            end
        end
    end

endmodule

// File: rtl/operand_forward_unit.sv
// Forwarding network: producer tag pipeline, per-source select, load-use detect, hit counter.
module operand_forward_unit
    import operand_forward_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    operand_forward_unit_if.slave  fwd_if
);
    localparam int SEL_W = sel_width(FWD_DEPTH);
    localparam int NH_W  = $clog2(NUM_SRC + 1);
    localparam int SUM_W = CNT_W + 1;

    // Index k-1 holds producer stage k (0 = EX/MEM).
    logic [FWD_DEPTH-1:0]             vld_pipe_q, vld_pipe_d;
    logic [FWD_DEPTH-1:0]             wr_pipe_q, wr_pipe_d;
    logic [FWD_DEPTH-1:0]             mem_pipe_q, mem_pipe_d;
    logic [FWD_DEPTH-1:0][REG_AW-1:0] rd_pipe_q, rd_pipe_d;
    logic [FWD_DEPTH-1:0]             fwd_en;
    logic [NUM_SRC-1:0][SEL_W-1:0]    sel;
    logic [NUM_SRC-1:0][DATA_W-1:0]   opnd;
    logic [CNT_W-1:0]                 hits_q, hits_d;
    logic [NH_W-1:0]                  nhits;
    logic [SUM_W-1:0]                 hits_sum;
    logic                             id_hit;

    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        wr_pipe_d     = wr_pipe_q;
        mem_pipe_d    = mem_pipe_q;
        rd_pipe_d     = rd_pipe_q;
        vld_pipe_d[0] = fwd_if.ex_valid_i & ~fwd_if.flush_i;
        wr_pipe_d[0]  = fwd_if.ex_regwrite_i;
        mem_pipe_d[0] = fwd_if.ex_memread_i;
        rd_pipe_d[0]  = fwd_if.ex_rd_i;
        for (int k = 1; k < FWD_DEPTH; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            wr_pipe_d[k]  = wr_pipe_q[k-1];
            mem_pipe_d[k] = mem_pipe_q[k-1];
            rd_pipe_d[k]  = rd_pipe_q[k-1];
        end
    end

    // x0 writers are never eligible, so reads of x0 always come from the RF path.
    always_comb begin
        fwd_en = '0;
        for (int k = 0; k < FWD_DEPTH; k++)
            fwd_en[k] = vld_pipe_q[k] & wr_pipe_q[k] & (rd_pipe_q[k] != '0);
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_operand_select #(
            .DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)
        ) u_sel (
            .rs_i        (fwd_if.ex_rs_i[s]),
            .rf_data_i   (fwd_if.ex_rf_data_i[s]),
            .fwd_en_i    (fwd_en),
            .tag_rd_i    (rd_pipe_q),
            .stage_data_i(fwd_if.stage_data_i),
            .sel_o       (sel[s]),
            .opnd_o      (opnd[s])
        );

        // A load one stage ahead has no data yet; the load-use stall must have prevented this.
        a_no_load_fwd : assert property (@(posedge clk_i) disable iff (!rst_i)
            !((sel[s] == SEL_W'(1)) && mem_pipe_q[0]));
    end

    always_comb begin
        id_hit = 1'b0;
        for (int s = 0; s < NUM_SRC; s++)
            id_hit = id_hit | (fwd_if.id_rs_used_i[s] & (fwd_if.id_rs_i[s] == fwd_if.ex_rd_i));
    end

    always_comb begin
        nhits = '0;
        for (int s = 0; s < NUM_SRC; s++)
            if (sel[s] != SEL_W'(FWD_SEL_RF)) nhits = nhits + NH_W'(1);
        hits_sum = {1'b0, hits_q} + SUM_W'(nhits);
        hits_d   = hits_sum[CNT_W] ? '1 : hits_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_pipe_q <= '0;
            wr_pipe_q  <= '0;
            mem_pipe_q <= '0;
            rd_pipe_q  <= '0;
            hits_q     <= '0;
        end else if (!fwd_if.stall_i) begin
            vld_pipe_q <= vld_pipe_d;
            wr_pipe_q  <= wr_pipe_d;
            mem_pipe_q <= mem_pipe_d;
            rd_pipe_q  <= rd_pipe_d;
            hits_q     <= hits_d;
        end
    end

    assign fwd_if.fwd_sel_o        = sel;
    assign fwd_if.ex_opnd_o        = opnd;
    assign fwd_if.fwd_hits_o       = hits_q;
    assign fwd_if.load_use_stall_o = rst_i & fwd_if.ex_valid_i & fwd_if.ex_memread_i
                                   & fwd_if.ex_regwrite_i & (fwd_if.ex_rd_i != '0)
                                   & ~fwd_if.flush_i & id_hit;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Directed checks of forwarding priority, x0, load-use, stall/flush, reset and counter saturation.
module tb_operand_forward_unit;
    localparam logic [31:0] RF0 = 32'hA0A0_0000;
    localparam logic [31:0] RF1 = 32'hB1B1_0001;
    localparam logic [31:0] SD1 = 32'h1111_1111;
    localparam logic [31:0] SD2 = 32'h2222_2222;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    operand_forward_unit_if #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .CNT_W(16)) fif ();

    operand_forward_unit #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .fwd_if(fif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ex(input logic v, input logic [4:0] rd, input logic wr, input logic mr,
                      input logic [4:0] rs0, input logic [4:0] rs1);
        fif.ex_valid_i    = v;
        fif.ex_rd_i       = rd;
        fif.ex_regwrite_i = wr;
        fif.ex_memread_i  = mr;
        fif.ex_rs_i[0]    = rs0;
        fif.ex_rs_i[1]    = rs1;
    endtask

    task automatic chk_src(input string tag, input logic [1:0] s0, input logic [31:0] d0,
                           input logic [1:0] s1, input logic [31:0] d1);
        chk({tag, ".sel0"}, 64'(fif.fwd_sel_o[0]), 64'(s0));
        chk({tag, ".op0"},  64'(fif.ex_opnd_o[0]), 64'(d0));
        chk({tag, ".sel1"}, 64'(fif.fwd_sel_o[1]), 64'(s1));
        chk({tag, ".op1"},  64'(fif.ex_opnd_o[1]), 64'(d1));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        fif.stall_i         = 1'b0;
        fif.flush_i         = 1'b0;
        fif.ex_rf_data_i[0] = RF0;
        fif.ex_rf_data_i[1] = RF1;
        fif.stage_data_i[0] = SD1;
        fif.stage_data_i[1] = SD2;
        // Load-use condition present during reset must stay masked.
        ex(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0);
        fif.id_rs_i[0]      = 5'd7;
        fif.id_rs_i[1]      = 5'd0;
        fif.id_rs_used_i    = 2'b01;
        #12;
        chk_src("rst", 2'd0, RF0, 2'd0, RF1);
        chk("rst.hits", 64'(fif.fwd_hits_o), 64'd0);
        chk("rst.lus", 64'(fif.load_use_stall_o), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        fif.id_rs_used_i = 2'b00;
        // A: add x5
        ex(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
        #1 chk_src("A", 2'd0, RF0, 2'd0, RF1);

        // B: writes x5 again, reads x5 from EX/MEM
        @(negedge clk);
        ex(1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 5'd3);
        #1 chk_src("B", 2'd1, SD1, 2'd0, RF1);
        chk("B.hits", 64'(fif.fwd_hits_o), 64'd0);

        // C: x5 at both stages -> youngest wins
        @(negedge clk);
        chk("C.hits", 64'(fif.fwd_hits_o), 64'd1);
        ex(1'b1, 5'd9, 1'b0, 1'b0, 5'd3, 5'd5);
        #1 chk_src("C", 2'd0, RF0, 2'd1, SD1);

        // D: stage-1 is a non-writer, x5 now only at MEM/WB
        @(negedge clk);
        chk("D.hits", 64'(fif.fwd_hits_o), 64'd2);
        ex(1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd5);
        #1 chk_src("D", 2'd0, RF0, 2'd2, SD2);

        // E/F: producer writes x0, consumer reads x0
        @(negedge clk);
        chk("E.hits", 64'(fif.fwd_hits_o), 64'd3);
        ex(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
        @(negedge clk);
        ex(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 5'd0);
        #1 chk_src("F", 2'd0, RF0, 2'd0, RF1);

        // G: lw x7 in EX, ID reads x7
        @(negedge clk);
        chk("G.hits", 64'(fif.fwd_hits_o), 64'd3);
        ex(1'b1, 5'd7, 1'b1, 1'b1, 5'd1, 5'd0);
        fif.id_rs_i[0]   = 5'd7;
        fif.id_rs_used_i = 2'b00;
        #1 chk("G.lus_unused", 64'(fif.load_use_stall_o), 64'd0);
        fif.id_rs_used_i = 2'b01;
        #1 chk("G.lus", 64'(fif.load_use_stall_o), 64'd1);
        chk("G.sel0", 64'(fif.fwd_sel_o[0]), 64'd1);

        // H: bubble in EX, consumer held in ID
        @(negedge clk);
        ex(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        #1 chk("H.lus", 64'(fif.load_use_stall_o), 64'd0);
        chk_src("H", 2'd0, RF0, 2'd0, RF1);

        // I: consumer reaches EX, load data from MEM/WB
        @(negedge clk);
        chk("I.hits", 64'(fif.fwd_hits_o), 64'd4);
        fif.id_rs_used_i = 2'b00;
        ex(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd7);
        #1 chk_src("I", 2'd2, SD2, 2'd2, SD2);
        chk("I.lus", 64'(fif.load_use_stall_o), 64'd0);

        // J: three stalled cycles (flush during stall ignored)
        @(negedge clk);
        chk("J.hits", 64'(fif.fwd_hits_o), 64'd6);
        fif.stall_i = 1'b1;
        ex(1'b1, 5'd10, 1'b1, 1'b0, 5'd8, 5'd0);
        for (int i = 0; i < 3; i++) begin
            fif.flush_i = (i == 1);
            #1 chk("J.sel0", 64'(fif.fwd_sel_o[0]), 64'd1);
            @(negedge clk);
            chk("J.hits_frozen", 64'(fif.fwd_hits_o), 64'd6);
        end
        fif.stall_i = 1'b0;
        fif.flush_i = 1'b1;
        #1 chk_src("Jrel", 2'd1, SD1, 2'd0, RF1);

        // K: flushed producer of x10 must not forward
        @(negedge clk);
        chk("K.hits", 64'(fif.fwd_hits_o), 64'd7);
        fif.flush_i = 1'b0;
        ex(1'b1, 5'd0, 1'b0, 1'b0, 5'd10, 5'd8);
        #1 chk_src("K", 2'd0, RF0, 2'd2, SD2);

        // L/M/N: fill both stages, then reset mid-operation
        @(negedge clk);
        ex(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 5'd0);
        @(negedge clk);
        ex(1'b1, 5'd13, 1'b1, 1'b0, 5'd0, 5'd0);
        @(negedge clk);
        chk("N.hits", 64'(fif.fwd_hits_o), 64'd8);
        ex(1'b0, 5'd0, 1'b0, 1'b0, 5'd12, 5'd13);
        #1 chk_src("N", 2'd2, SD2, 2'd1, SD1);
        #1 rst_n = 1'b0;
        #1 chk_src("Nrst", 2'd0, RF0, 2'd0, RF1);
        chk("Nrst.hits", 64'(fif.fwd_hits_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_src("Nrel", 2'd0, RF0, 2'd0, RF1);

        // Saturation: both sources hit every cycle
        ex(1'b1, 5'd20, 1'b1, 1'b0, 5'd20, 5'd20);
        @(negedge clk);
        chk("S.first", 64'(fif.fwd_hits_o), 64'd0);
        for (int i = 0; i < 32767; i++) @(posedge clk);
        @(negedge clk);
        chk("S.near", 64'(fif.fwd_hits_o), 64'hFFFE);
        @(negedge clk);
        chk("S.sat", 64'(fif.fwd_hits_o), 64'hFFFF);
        @(negedge clk);
        @(negedge clk);
        chk("S.hold", 64'(fif.fwd_hits_o), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
